// File: rtl/brz_bf_pkg.sv
// brz_bf_pkg: shared enums and sizing helpers for brz_binary_func_sync.
// Sizing helpers let the top derive digit count and counter width.
package brz_bf_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      COMPUTE,
      DONE
   } state_e;

   function automatic int n_digits(input int w, input int d);
      return w / d;
   endfunction

   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Encodings 5..7 fold onto ADD.
   function automatic op_e decode_op(input logic [2:0] raw);
      op_e o;
      case (raw)
         3'd1:    o = OP_SUB;
         3'd2:    o = OP_AND;
         3'd3:    o = OP_OR;
         3'd4:    o = OP_XOR;
         default: o = OP_ADD;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/brz_binary_func_sync_if.sv
// Handshake bundle for brz_binary_func_sync: go, operand pulls, result pull.
// BRZ_BF_OVERFLOW_EN adds the out_overflow flag.
interface brz_binary_func_sync_if #(
   parameter int WIDTH = 8
);
   logic             go_req;
   logic             go_ack;
   logic [2:0]       op;
   logic             inpA_req;
   logic             inpA_ack;
   logic [WIDTH-1:0] inpA_data;
   logic             inpB_req;
   logic             inpB_ack;
   logic [WIDTH-1:0] inpB_data;
   logic             out_req;
   logic             out_ack;
   logic [WIDTH-1:0] out_data;
   logic             out_carry;
   logic             out_zero;
`ifdef BRZ_BF_OVERFLOW_EN
   logic             out_overflow;
`endif

   modport master (
      output go_req, op, inpA_ack, inpA_data,
      output inpB_ack, inpB_data, out_req,
      input  go_ack, inpA_req, inpB_req, out_ack,
      input  out_data, out_carry, out_zero
`ifdef BRZ_BF_OVERFLOW_EN
      , input out_overflow
`endif
   );

   modport slave (
      input  go_req, op, inpA_ack, inpA_data,
      input  inpB_ack, inpB_data, out_req,
      output go_ack, inpA_req, inpB_req, out_ack,
      output out_data, out_carry, out_zero
`ifdef BRZ_BF_OVERFLOW_EN
      , output out_overflow
`endif
   );

endinterface

// File: rtl/brz_binary_func_sync_digit.sv
// brz_bf_digit: one DIGIT-wide slice of the arithmetic/logic function.
// Subtraction inverts b here; the caller supplies carry-in 1.
module brz_bf_digit
   import brz_bf_pkg::*;
#(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] a,
   input  logic [DIGIT-1:0] b,
   input  op_e              op,
   input  logic             cin,
   output logic [DIGIT-1:0] r,
   output logic             cout,
   output logic             a_msb,
   output logic             b_msb
);
   logic [DIGIT-1:0] bx;
   logic [DIGIT:0]   sum;

   always_comb begin
      bx   = (op == OP_SUB) ? ~b : b;
      sum  = {1'b0, a} + {1'b0, bx} + {{DIGIT{1'b0}}, cin};
      r    = sum[DIGIT-1:0];
      cout = 1'b0;
      unique case (1'b1)
         op == OP_AND: r = a & b;
         op == OP_OR:  r = a | b;
         op == OP_XOR: r = a ^ b;
         default:      cout = sum[DIGIT];
      endcase
      a_msb = a[DIGIT-1];
      b_msb = bx[DIGIT-1];
   end

endmodule

// File: rtl/brz_binary_func_sync.sv
// brz_binary_func_sync: clocked digit-serial BinaryFunc, LSB digit first.
// Define BRZ_BF_OVERFLOW_EN for the signed overflow flag.
module brz_binary_func_sync
   import brz_bf_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   brz_binary_func_sync_if.slave bus
);
   localparam int N  = n_digits(WIDTH, DIGIT);
   localparam int CW = cnt_bits(N);
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_cfg_err
      $error("WIDTH must be a positive multiple of DIGIT");
   end

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] sh_q, sh_d, data_q, data_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             a_got_q, a_got_d, b_got_q, b_got_d;
   logic             a_req_q, a_req_d, b_req_q, b_req_d;
   logic             carry_q, carry_d;
   logic             go_ack_q, go_ack_d;
   logic             out_ack_q, out_ack_d;
   logic             cflag_q, cflag_d, zflag_q, zflag_d;
`ifdef BRZ_BF_OVERFLOW_EN
   logic             ovf_q, ovf_d;
   logic             sa_msb, sb_msb;
`endif

   logic [DIGIT-1:0] sa, sb, sr;
   logic             scout;
   logic [WIDTH-1:0] res;

   always_comb begin
      sa  = a_q[int'(cnt_q) * DIGIT +: DIGIT];
      sb  = b_q[int'(cnt_q) * DIGIT +: DIGIT];
      res = sh_q;
      res[int'(cnt_q) * DIGIT +: DIGIT] = sr;
   end

   brz_bf_digit #(.DIGIT(DIGIT)) u_digit (
      .a     (sa),
      .b     (sb),
      .op    (op_q),
      .cin   (carry_q),
      .r     (sr),
      .cout  (scout),
`ifdef BRZ_BF_OVERFLOW_EN
      .a_msb (sa_msb),
      .b_msb (sb_msb)
`else
      .a_msb (),
      .b_msb ()
`endif
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      sh_d      = sh_q;
      data_d    = data_q;
      cnt_d     = cnt_q;
      a_got_d   = a_got_q;
      b_got_d   = b_got_q;
      a_req_d   = a_req_q;
      b_req_d   = b_req_q;
      carry_d   = carry_q;
      go_ack_d  = go_ack_q;
      cflag_d   = cflag_q;
      zflag_d   = zflag_q;
      out_ack_d = bus.out_req;
`ifdef BRZ_BF_OVERFLOW_EN
      ovf_d     = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (bus.go_req) begin
               state_d = FETCH;
               op_d    = decode_op(bus.op);
               a_got_d = 1'b0;
               b_got_d = 1'b0;
               a_req_d = 1'b1;
               b_req_d = 1'b1;
            end
         end
         FETCH: begin
            if (!a_got_q && bus.inpA_ack) begin
               a_d     = bus.inpA_data;
               a_got_d = 1'b1;
               a_req_d = 1'b0;
            end
            if (!b_got_q && bus.inpB_ack) begin
               b_d     = bus.inpB_data;
               b_got_d = 1'b1;
               b_req_d = 1'b0;
            end
            // Wait for return-to-zero on both channels.
            if (a_got_q && b_got_q &&
                !bus.inpA_ack && !bus.inpB_ack) begin
               state_d = COMPUTE;
               cnt_d   = '0;
               carry_d = (op_q == OP_SUB);
            end
         end
         COMPUTE: begin
            sh_d    = res;
            carry_d = scout;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               data_d   = res;
               cflag_d  = scout;
               zflag_d  = (res == '0);
`ifdef BRZ_BF_OVERFLOW_EN
               ovf_d    = (op_q == OP_ADD || op_q == OP_SUB) &&
                          (sa_msb == sb_msb) &&
                          (sr[DIGIT-1] != sa_msb);
`endif
               state_d  = DONE;
               go_ack_d = 1'b1;
            end
         end
         DONE: begin
            if (!bus.go_req) begin
               state_d  = IDLE;
               go_ack_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         op_q      <= OP_ADD;
         a_q       <= '0;
         b_q       <= '0;
         sh_q      <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         a_got_q   <= 1'b0;
         b_got_q   <= 1'b0;
         a_req_q   <= 1'b0;
         b_req_q   <= 1'b0;
         carry_q   <= 1'b0;
         go_ack_q  <= 1'b0;
         out_ack_q <= 1'b0;
         cflag_q   <= 1'b0;
         zflag_q   <= 1'b0;
`ifdef BRZ_BF_OVERFLOW_EN
         ovf_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sh_q      <= sh_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         a_got_q   <= a_got_d;
         b_got_q   <= b_got_d;
         a_req_q   <= a_req_d;
         b_req_q   <= b_req_d;
         carry_q   <= carry_d;
         go_ack_q  <= go_ack_d;
         out_ack_q <= out_ack_d;
         cflag_q   <= cflag_d;
         zflag_q   <= zflag_d;
`ifdef BRZ_BF_OVERFLOW_EN
         ovf_q     <= ovf_d;
`endif
      end
   end

   assign bus.go_ack    = go_ack_q;
   assign bus.inpA_req  = a_req_q;
   assign bus.inpB_req  = b_req_q;
   assign bus.out_ack   = out_ack_q;
   assign bus.out_data  = data_q;
   assign bus.out_carry = cflag_q;
   assign bus.out_zero  = zflag_q;
`ifdef BRZ_BF_OVERFLOW_EN
   assign bus.out_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_brz_binary_func_sync.sv
// Bench for brz_binary_func_sync: directed and random ops vs arithmetic model.
// Covers DIGIT=4 and DIGIT=8 builds; BRZ_BF_OVERFLOW_EN adds overflow checks.
module tb_brz_binary_func_sync;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   drop_a, drop_b;
   logic [7:0] last_r = 8'h00;

   brz_binary_func_sync_if #(.WIDTH(8)) bus ();
   brz_binary_func_sync_if #(.WIDTH(8)) bus8 ();

   brz_binary_func_sync #(.WIDTH(8), .DIGIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   brz_binary_func_sync #(.WIDTH(8), .DIGIT(8)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Plain arithmetic view of each function.
   function automatic void model(input logic [2:0] o, input logic [7:0] a,
                                 input logic [7:0] b, output logic [7:0] r,
                                 output logic c, output logic v);
      int sa, sb, s;
      sa = $signed(a);
      sb = $signed(b);
      c  = 1'b0;
      v  = 1'b0;
      case (o)
         3'd1: begin
            r = a - b;
            c = (a >= b);
            s = sa - sb;
            v = (s < -128 || s > 127);
         end
         3'd2: r = a & b;
         3'd3: r = a | b;
         3'd4: r = a ^ b;
         default: begin
            r = a + b;
            c = (int'(a) + int'(b)) > 255;
            s = sa + sb;
            v = (s < -128 || s > 127);
         end
      endcase
   endfunction

   task automatic set_ack(input bit isb, input logic v, input logic [7:0] d);
      if (isb) begin
         bus.inpB_ack  = v;
         bus.inpB_data = d;
      end else begin
         bus.inpA_ack  = v;
         bus.inpA_data = d;
      end
   endtask

   // Operand producer: answers a pull after dly cycles, holds ack hold cycles.
   task automatic produce(input bit isb, input logic [7:0] val,
                          input int dly, input int hold);
      int t;
      t = 0;
      do begin
         @(posedge clk); #1;
         t++;
      end while (!(isb ? bus.inpB_req : bus.inpA_req) && t < 40);
      chk(isb ? "req_b_seen" : "req_a_seen",
          isb ? bus.inpB_req : bus.inpA_req, 1);
      repeat (dly) begin
         @(posedge clk); #1;
      end
      set_ack(isb, 1'b1, val);
      for (int i = 1; i < hold; i++) begin
         @(posedge clk); #1;
         set_ack(isb, 1'b1, 8'($urandom));
      end
      @(posedge clk); #1;
      set_ack(isb, 1'b0, 8'($urandom));
      chk(isb ? "req_b_low" : "req_a_low",
          isb ? bus.inpB_req : bus.inpA_req, 0);
      if (isb) drop_b = cyc;
      else     drop_a = cyc;
   endtask

   task automatic start_fetch(input logic [2:0] o, input logic [7:0] a,
                              input logic [7:0] b, input int dla, input int dlb,
                              input int ha, input int hb, output int ex);
      @(posedge clk); #1;
      bus.go_req = 1'b1;
      bus.op     = o;
      fork
         produce(1'b0, a, dla, ha);
         produce(1'b1, b, dlb, hb);
      join
      bus.op = 3'($urandom);
      ex = (drop_a > drop_b) ? drop_a : drop_b;
   endtask

   task automatic run_op(input string tag, input logic [2:0] o,
                         input logic [7:0] a, input logic [7:0] b,
                         input int dla, input int dlb,
                         input int ha, input int hb);
      int ex, t;
      logic [7:0] r;
      logic c, v;
      start_fetch(o, a, b, dla, dlb, ha, hb, ex);
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus.go_ack && t < 40);
      chk({tag, "_lat"}, 32'(cyc - ex), 3);
      model(o, a, b, r, c, v);
      chk({tag, "_data"}, {24'h0, bus.out_data}, {24'h0, r});
      chk({tag, "_carry"}, {31'h0, bus.out_carry}, {31'h0, c});
      chk({tag, "_zero"}, {31'h0, bus.out_zero}, {31'h0, (r == 8'h00)});
`ifdef BRZ_BF_OVERFLOW_EN
      chk({tag, "_ovf"}, {31'h0, bus.out_overflow}, {31'h0, v});
`endif
      last_r = r;
      @(posedge clk); #1;
      bus.go_req = 1'b0;
      @(negedge clk);
      chk({tag, "_ack_hold"}, {31'h0, bus.go_ack}, 1);
      @(negedge clk);
      chk({tag, "_ack_rtz"}, {31'h0, bus.go_ack}, 0);
   endtask

   initial begin
      int ex, t;
      bus.go_req    = 1'b0;
      bus.op        = 3'd0;
      bus.inpA_ack  = 1'b0;
      bus.inpA_data = 8'h00;
      bus.inpB_ack  = 1'b0;
      bus.inpB_data = 8'h00;
      bus.out_req   = 1'b0;
      bus8.go_req    = 1'b0;
      bus8.op        = 3'd0;
      bus8.inpA_ack  = 1'b0;
      bus8.inpA_data = 8'h00;
      bus8.inpB_ack  = 1'b0;
      bus8.inpB_data = 8'h00;
      bus8.out_req   = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_go_ack", {31'h0, bus.go_ack}, 0);
      chk("rst_req_a", {31'h0, bus.inpA_req}, 0);
      chk("rst_req_b", {31'h0, bus.inpB_req}, 0);
      chk("rst_out_ack", {31'h0, bus.out_ack}, 0);
      chk("rst_data", {24'h0, bus.out_data}, 0);
      chk("rst_carry", {31'h0, bus.out_carry}, 0);
      chk("rst_zero", {31'h0, bus.out_zero}, 0);
      chk("rst8_data", {24'h0, bus8.out_data}, 0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_op("add_f0_20", 3'd0, 8'hF0, 8'h20, 0, 1, 1, 1);
      run_op("sub_eq", 3'd1, 8'h05, 8'h05, 1, 0, 2, 1);
      run_op("sub_neg", 3'd1, 8'h03, 8'h05, 0, 0, 1, 1);
      run_op("add_ovf", 3'd0, 8'h7F, 8'h01, 2, 1, 1, 2);
      run_op("skew_b", 3'd0, 8'h3C, 8'h5A, 0, 4, 1, 3);
      run_op("op7_add", 3'd7, 8'h9C, 8'h77, 0, 0, 2, 2);

      @(posedge clk); #1;
      bus.out_req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("pull_ack_pre", {31'h0, bus.out_ack}, 1);
      chk("pull_data_pre", {24'h0, bus.out_data}, {24'h0, last_r});
      run_op("xor_pull", 3'd4, 8'hAA, 8'hFF, 1, 0, 2, 1);
      chk("pull_ack_post", {31'h0, bus.out_ack}, 1);
      bus.out_req = 1'b0;
      @(negedge clk);
      chk("pull_ack_rtz", {31'h0, bus.out_ack}, 0);

      for (int i = 0; i < 16; i++) begin
         run_op("rnd", 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
      end

      run_op("pre_abort", 3'd0, 8'h80, 8'h81, 0, 0, 1, 1);
      @(posedge clk); #1;
      bus.out_req = 1'b1;
      start_fetch(3'd1, 8'h09, 8'h04, 0, 1, 1, 1, ex);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      chk("abort_go_ack", {31'h0, bus.go_ack}, 0);
      chk("abort_req_a", {31'h0, bus.inpA_req}, 0);
      chk("abort_req_b", {31'h0, bus.inpB_req}, 0);
      chk("abort_out_ack", {31'h0, bus.out_ack}, 0);
      chk("abort_data", {24'h0, bus.out_data}, 0);
      chk("abort_carry", {31'h0, bus.out_carry}, 0);
      chk("abort_zero", {31'h0, bus.out_zero}, 0);
`ifdef BRZ_BF_OVERFLOW_EN
      chk("abort_ovf", {31'h0, bus.out_overflow}, 0);
`endif
      bus.go_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      run_op("after_abort", 3'd0, 8'h01, 8'h01, 0, 0, 1, 1);
      bus.out_req = 1'b0;

      @(posedge clk); #1;
      bus8.go_req = 1'b1;
      bus8.op     = 3'd0;
      t = 0;
      do begin
         @(posedge clk); #1;
         t++;
      end while (!(bus8.inpA_req && bus8.inpB_req) && t < 20);
      chk("d8_req", {31'h0, bus8.inpA_req & bus8.inpB_req}, 1);
      bus8.inpA_ack  = 1'b1;
      bus8.inpA_data = 8'h01;
      bus8.inpB_ack  = 1'b1;
      bus8.inpB_data = 8'h01;
      @(posedge clk); #1;
      bus8.inpA_ack = 1'b0;
      bus8.inpB_ack = 1'b0;
      ex = cyc;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!bus8.go_ack && t < 20);
      chk("d8_lat", 32'(cyc - ex), 2);
      chk("d8_data", {24'h0, bus8.out_data}, 32'h02);
      chk("d8_carry", {31'h0, bus8.out_carry}, 0);
      chk("d8_zero", {31'h0, bus8.out_zero}, 0);
      @(posedge clk); #1;
      bus8.go_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("d8_ack_rtz", {31'h0, bus8.go_ack}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
